exec_unit: RTL and testbench

Execution/memory block of the 8-bit pipelined processor: a combinational 8-bit ALU, an 8-bit barrel shifter, the carry/zero flag register, and a 256×8 data memory. The EX stage drives the ALU and shifter. The MEM stage drives the data memory. The flag register is the single architectural C/Z state used by branches and carry-using ALU ops.

---
 rtl/exec_unit_pkg.sv | 20 ++
 rtl/exec_unit_if.sv | 39 +++
 rtl/exec_alu.sv | 33 +++
 rtl/exec_dmem.sv | 20 ++
 rtl/exec_shifter.sv | 33 +++
 rtl/exec_unit.sv | 63 ++++++
 tb/tb_exec_unit.sv | 226 ++++++++++++++++++++++
 7 files changed

// File: rtl/exec_unit_pkg.sv
// Shared constants and types for the EX/MEM execution block.
package exec_unit_pkg;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_NOT   = 3'b101,
    ALU_PASSB = 3'b110,
    ALU_PASSA = 3'b111
  } alu_op_e;

  localparam logic SH_LEFT  = 1'b0;
  localparam logic SH_RIGHT = 1'b1;
endpackage

// File: rtl/exec_unit_if.sv
// EX/MEM datapath bundle: ALU, shifter, flag control and data-memory port.
interface exec_unit_if;
  import exec_unit_pkg::*;

  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic              alu_use_carry;
  logic [DATA_W-1:0] alu_out;
  logic              alu_co, alu_z;

  logic [DATA_W-1:0] sh_data;
  logic [2:0]        sh_count;
  logic              sh_dir, sh_ro_bar;
  logic [DATA_W-1:0] sh_out;
  logic              sh_c, sh_z;

  logic              select_c, select_z, write_c, write_z;
  logic              c, z;

  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  modport master (
    output alu_op, alu_a, alu_b, alu_use_carry,
    output sh_data, sh_count, sh_dir, sh_ro_bar,
    output select_c, select_z, write_c, write_z,
    output mem_write, mem_addr, mem_wdata,
    input  alu_out, alu_co, alu_z, sh_out, sh_c, sh_z, c, z, mem_rdata
  );

  modport slave (
    input  alu_op, alu_a, alu_b, alu_use_carry,
    input  sh_data, sh_count, sh_dir, sh_ro_bar,
    input  select_c, select_z, write_c, write_z,
    input  mem_write, mem_addr, mem_wdata,
    output alu_out, alu_co, alu_z, sh_out, sh_c, sh_z, c, z, mem_rdata
  );
endinterface

// File: rtl/exec_alu.sv
// Combinational 8-bit ALU; co is carry for ADD, borrow for SUB, 0 otherwise.
module exec_alu
  import exec_unit_pkg::*;
(
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cin_i,
  output logic [DATA_W-1:0] out_o,
  output logic              co_o,
  output logic              z_o
);
  logic [DATA_W:0] res;

  // 9-bit arithmetic: bit 8 is carry on add, and the wrap-around sign on sub is exactly the borrow.
  always_comb begin
    res = '0;
    case (op_i)
      ALU_ADD:   res = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
      ALU_SUB:   res = {1'b0, a_i} - {1'b0, b_i} - {{DATA_W{1'b0}}, cin_i};
      ALU_AND:   res = {1'b0, a_i & b_i};
      ALU_OR:    res = {1'b0, a_i | b_i};
      ALU_XOR:   res = {1'b0, a_i ^ b_i};
      ALU_NOT:   res = {1'b0, ~a_i};
      ALU_PASSB: res = {1'b0, b_i};
      default:   res = {1'b0, a_i};
    endcase
  end

  assign out_o = res[DATA_W-1:0];
  assign co_o  = res[DATA_W];
  assign z_o   = (out_o == '0);
endmodule

// File: rtl/exec_dmem.sv
// 256x8 data memory: asynchronous read, synchronous write, writes gated off during reset.
module exec_dmem
  import exec_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // Contents survive reset; only the write strobe is qualified by it.
  always_ff @(posedge clk) begin
    if (we_i && rst_n_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/exec_shifter.sv
// Combinational barrel shifter/rotator; carry is the last bit pushed past the edge.
module exec_shifter
  import exec_unit_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        count_i,
  input  logic              dir_i,
  input  logic              ro_bar_i,
  output logic [DATA_W-1:0] out_o,
  output logic              c_o,
  output logic              z_o
);
  logic [2*DATA_W-1:0] lft, rgt;

  // Shift inside a double-width window: the spilled half supplies both rotate wrap bits
  // and the carry bit adjacent to the boundary (zero when the count is zero).
  assign lft = {{DATA_W{1'b0}}, data_i} << count_i;
  assign rgt = {data_i, {DATA_W{1'b0}}} >> count_i;

  always_comb begin
    out_o = data_i;
    c_o   = 1'b0;
    if (dir_i == SH_LEFT) begin
      out_o = ro_bar_i ? lft[DATA_W-1:0] : (lft[DATA_W-1:0] | lft[2*DATA_W-1:DATA_W]);
      c_o   = lft[DATA_W];
    end else begin
      out_o = ro_bar_i ? rgt[2*DATA_W-1:DATA_W] : (rgt[2*DATA_W-1:DATA_W] | rgt[DATA_W-1:0]);
      c_o   = rgt[DATA_W-1];
    end
  end

  assign z_o = (out_o == '0);
endmodule

// File: rtl/exec_unit.sv
// EX/MEM execution block: ALU, shifter, C/Z flag register and data memory.
module exec_unit
  import exec_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  exec_unit_if.slave   eu_if
);
  logic c_q, c_d, z_q, z_d;
  logic alu_cin;

  // Carry-using ops see the pre-edge flag even when they also write C.
  assign alu_cin = eu_if.alu_use_carry & c_q;

  exec_alu u_alu (
    .op_i  (eu_if.alu_op),
    .a_i   (eu_if.alu_a),
    .b_i   (eu_if.alu_b),
    .cin_i (alu_cin),
    .out_o (eu_if.alu_out),
    .co_o  (eu_if.alu_co),
    .z_o   (eu_if.alu_z)
  );

  exec_shifter u_sh (
    .data_i   (eu_if.sh_data),
    .count_i  (eu_if.sh_count),
    .dir_i    (eu_if.sh_dir),
    .ro_bar_i (eu_if.sh_ro_bar),
    .out_o    (eu_if.sh_out),
    .c_o      (eu_if.sh_c),
    .z_o      (eu_if.sh_z)
  );

  exec_dmem u_dmem (
    .clk     (clk),
    .rst_n_i (reset),
    .we_i    (eu_if.mem_write),
    .addr_i  (eu_if.mem_addr),
    .wdata_i (eu_if.mem_wdata),
    .rdata_o (eu_if.mem_rdata)
  );

  always_comb begin
    c_d = c_q;
    z_d = z_q;
    if (eu_if.write_c) c_d = eu_if.select_c ? eu_if.sh_c : eu_if.alu_co;
    if (eu_if.write_z) z_d = eu_if.select_z ? eu_if.sh_z : eu_if.alu_z;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      c_q <= c_d;
      z_q <= z_d;
    end
  end

  assign eu_if.c = c_q;
  assign eu_if.z = z_q;
endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed vector table, hand sequences, then random vs. a reference model.
module tb_exec_unit;
  import exec_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exec_unit_if eu();
  exec_unit dut (.clk(clk), .reset(reset), .eu_if(eu));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem_m [256];
  logic       c_m, z_m;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic [7:0] sd;
    logic [2:0] cnt;
    logic       dir, ro_bar;
    logic [7:0] exp_alu;
    logic       exp_co;
    logic [7:0] exp_sh;
    logic       exp_shc;
  } vec_t;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic idle();
    eu.alu_op = ALU_PASSA; eu.alu_a = 8'h01; eu.alu_b = 8'h00; eu.alu_use_carry = 1'b0;
    eu.sh_data = 8'h00; eu.sh_count = 3'd0; eu.sh_dir = SH_LEFT; eu.sh_ro_bar = 1'b1;
    eu.select_c = 1'b0; eu.select_z = 1'b0; eu.write_c = 1'b0; eu.write_z = 1'b0;
    eu.mem_write = 1'b0; eu.mem_addr = 8'h00; eu.mem_wdata = 8'h00;
  endtask

  // Reference ALU from plain integer arithmetic.
  function automatic void ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, output logic [7:0] o, output logic co);
    int s;
    co = 1'b0;
    case (op)
      3'd0: begin s = int'(a) + int'(b) + int'(cin); o = 8'(s % 256); co = (s > 255); end
      3'd1: begin co = (int'(a) < int'(b) + int'(cin)); s = int'(a) - int'(b) - int'(cin) + 256; o = 8'(s % 256); end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      3'd5: o = ~a;
      3'd6: o = b;
      default: o = a;
    endcase
  endfunction

  // Reference shifter: per output bit, find its source bit; wrap for rotate, zero for shift.
  function automatic void ref_sh(input logic [7:0] d, input int n, input logic left, input logic rot,
                                 output logic [7:0] o, output logic c);
    int src;
    for (int i = 0; i < 8; i++) begin
      src = left ? i - n : i + n;
      if (src >= 0 && src < 8) o[i] = d[src];
      else o[i] = rot ? d[(src + 8) % 8] : 1'b0;
    end
    if (n == 0) c = 1'b0;
    else c = left ? d[8 - n] : d[n - 1];
  endfunction

  // One model-checked cycle: inputs already driven (after negedge).
  task automatic model_cycle();
    logic [7:0] ao, so;
    logic       aco, sc, nc, nz;
    #1;
    ref_alu(eu.alu_op, eu.alu_a, eu.alu_b, eu.alu_use_carry & c_m, ao, aco);
    ref_sh(eu.sh_data, int'(eu.sh_count), eu.sh_dir == SH_LEFT, !eu.sh_ro_bar, so, sc);
    chk8("rnd_alu_out", eu.alu_out, ao);
    chk1("rnd_alu_co", eu.alu_co, aco);
    chk1("rnd_alu_z", eu.alu_z, ao == 8'h00);
    chk8("rnd_sh_out", eu.sh_out, so);
    chk1("rnd_sh_c", eu.sh_c, sc);
    chk1("rnd_sh_z", eu.sh_z, so == 8'h00);
    chk8("rnd_rdata", eu.mem_rdata, mem_m[eu.mem_addr]);
    nc = eu.select_c ? sc : aco;
    nz = eu.select_z ? (so == 8'h00) : (ao == 8'h00);
    if (eu.write_c) c_m = nc;
    if (eu.write_z) z_m = nz;
    if (eu.mem_write) mem_m[eu.mem_addr] = eu.mem_wdata;
    @(posedge clk); #1;
    chk1("rnd_c", eu.c, c_m);
    chk1("rnd_z", eu.z, z_m);
  endtask

  vec_t vt [9];

  initial begin
    vt[0] = '{3'd0, 8'hFF, 8'h01, 8'h81, 3'd1, SH_LEFT,  1'b1, 8'h00, 1'b1, 8'h02, 1'b1};
    vt[1] = '{3'd1, 8'h05, 8'h06, 8'h01, 3'd1, SH_RIGHT, 1'b0, 8'hFF, 1'b1, 8'h80, 1'b1};
    vt[2] = '{3'd2, 8'hF0, 8'h3C, 8'h81, 3'd0, SH_LEFT,  1'b1, 8'h30, 1'b0, 8'h81, 1'b0};
    vt[3] = '{3'd3, 8'hF0, 8'h0F, 8'h81, 3'd0, SH_RIGHT, 1'b0, 8'hFF, 1'b0, 8'h81, 1'b0};
    vt[4] = '{3'd4, 8'hAA, 8'hFF, 8'h01, 3'd7, SH_LEFT,  1'b1, 8'h55, 1'b0, 8'h80, 1'b0};
    vt[5] = '{3'd5, 8'h3C, 8'h00, 8'h80, 3'd7, SH_RIGHT, 1'b1, 8'hC3, 1'b0, 8'h01, 1'b0};
    vt[6] = '{3'd6, 8'h12, 8'h77, 8'hB4, 3'd3, SH_LEFT,  1'b0, 8'h77, 1'b0, 8'hA5, 1'b1};
    vt[7] = '{3'd7, 8'h00, 8'h99, 8'h01, 3'd1, SH_RIGHT, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1};
    vt[8] = '{3'd1, 8'h10, 8'h10, 8'hC0, 3'd2, SH_LEFT,  1'b1, 8'h00, 1'b0, 8'h00, 1'b1};

    idle();
    reset = 1'b0;
    #2;
    chk1("reset_c", eu.c, 1'b0);
    chk1("reset_z", eu.z, 1'b0);
    @(negedge clk); reset = 1'b1;

    // Initialise memory so every read is defined.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      eu.mem_write = 1'b1; eu.mem_addr = 8'(i); eu.mem_wdata = 8'(i) ^ 8'h3C;
      mem_m[i] = 8'(i) ^ 8'h3C;
    end
    @(negedge clk); idle();

    // Directed combinational vectors.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      eu.alu_op = vt[i].op; eu.alu_a = vt[i].a; eu.alu_b = vt[i].b;
      eu.sh_data = vt[i].sd; eu.sh_count = vt[i].cnt; eu.sh_dir = vt[i].dir; eu.sh_ro_bar = vt[i].ro_bar;
      #1;
      chk8($sformatf("vec%0d_alu_out", i), eu.alu_out, vt[i].exp_alu);
      chk1($sformatf("vec%0d_alu_co", i), eu.alu_co, vt[i].exp_co);
      chk1($sformatf("vec%0d_alu_z", i), eu.alu_z, vt[i].exp_alu == 8'h00);
      chk8($sformatf("vec%0d_sh_out", i), eu.sh_out, vt[i].exp_sh);
      chk1($sformatf("vec%0d_sh_c", i), eu.sh_c, vt[i].exp_shc);
      chk1($sformatf("vec%0d_sh_z", i), eu.sh_z, vt[i].exp_sh == 8'h00);
    end

    // ADD overflow writes both flags.
    @(negedge clk); idle();
    eu.alu_op = ALU_ADD; eu.alu_a = 8'hFF; eu.alu_b = 8'h01; eu.write_c = 1'b1; eu.write_z = 1'b1;
    @(posedge clk); #1;
    chk1("ovf_c", eu.c, 1'b1);
    chk1("ovf_z", eu.z, 1'b1);

    // Carry chain: consumes old C=1 while writing C.
    @(negedge clk); idle();
    eu.alu_op = ALU_ADD; eu.alu_a = 8'h10; eu.alu_b = 8'h20; eu.alu_use_carry = 1'b1; eu.write_c = 1'b1;
    #1;
    chk8("chain_out", eu.alu_out, 8'h31);
    @(posedge clk); #1;
    chk1("chain_c", eu.c, 1'b0);
    chk1("chain_z_held", eu.z, 1'b1);

    // Rotate right from shifter into C; z write disabled keeps z.
    @(negedge clk); idle();
    eu.sh_data = 8'h01; eu.sh_count = 3'd1; eu.sh_dir = SH_RIGHT; eu.sh_ro_bar = 1'b0;
    eu.select_c = 1'b1; eu.write_c = 1'b1;
    @(posedge clk); #1;
    chk1("rot_c", eu.c, 1'b1);

    // Memory read-during-write returns old data; new data after the edge.
    @(negedge clk); idle();
    eu.mem_addr = 8'h10; eu.mem_wdata = 8'h5A; eu.mem_write = 1'b1;
    #1;
    chk8("mem_old", eu.mem_rdata, 8'h2C);
    @(posedge clk); #1;
    chk8("mem_new", eu.mem_rdata, 8'h5A);
    @(negedge clk);
    eu.mem_addr = 8'hFF; eu.mem_wdata = 8'hA5;
    @(negedge clk); eu.mem_write = 1'b0;
    #1;
    chk8("mem_ff", eu.mem_rdata, 8'hA5);
    eu.mem_addr = 8'h10;
    #1;
    chk8("mem_10_kept", eu.mem_rdata, 8'h5A);
    mem_m[8'h10] = 8'h5A; mem_m[8'hFF] = 8'hA5;

    // Reset mid-operation clears flags asynchronously and blocks writes.
    @(negedge clk); idle();
    eu.alu_op = ALU_ADD; eu.alu_a = 8'hFF; eu.alu_b = 8'h01; eu.write_c = 1'b1; eu.write_z = 1'b1;
    @(posedge clk); #1;
    chk1("pre_rst_c", eu.c, 1'b1);
    chk1("pre_rst_z", eu.z, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk1("async_rst_c", eu.c, 1'b0);
    chk1("async_rst_z", eu.z, 1'b0);
    @(negedge clk); idle();
    eu.mem_write = 1'b1; eu.mem_addr = 8'h10; eu.mem_wdata = 8'h33;
    @(posedge clk); #1;
    @(negedge clk); eu.mem_write = 1'b0; reset = 1'b1;
    #1;
    chk8("rst_mem_blocked", eu.mem_rdata, 8'h5A);
    chk1("rst_c_held", eu.c, 1'b0);
    c_m = 1'b0; z_m = 1'b0;

    // Randomised phase against the reference model.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      eu.alu_op = 3'($urandom_range(0, 7));
      eu.alu_a = 8'($urandom); eu.alu_b = 8'($urandom);
      eu.alu_use_carry = 1'($urandom);
      eu.sh_data = 8'($urandom); eu.sh_count = 3'($urandom);
      eu.sh_dir = 1'($urandom); eu.sh_ro_bar = 1'($urandom);
      eu.select_c = 1'($urandom); eu.select_z = 1'($urandom);
      eu.write_c = 1'($urandom); eu.write_z = 1'($urandom);
      eu.mem_write = ($urandom_range(0, 3) == 0);
      eu.mem_addr = 8'($urandom); eu.mem_wdata = 8'($urandom);
      model_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
